// File: rtl/quad_step_decoder.sv
// Quadrature A/B front-end: per-channel synchronizer and persistence filter,
// then a phase decoder producing a one-cycle step pulse, direction and error flag.

module quad_step_chan #(
  parameter int FILT_LEN = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic i_in,
  output logic o_acc
);
  localparam logic [3:0] LIM = 4'(FILT_LEN - 1);

  logic       r_s1, r_s2, r_acc;
  logic [3:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1  <= 1'b0;
      r_s2  <= 1'b0;
      r_acc <= 1'b0;
      r_cnt <= '0;
    end else begin
      r_s1 <= i_in;
      r_s2 <= r_s1;
      // Any return to the accepted value restarts the persistence count.
      if (r_s2 == r_acc) begin
        r_cnt <= '0;
      end else if (r_cnt == LIM) begin
        r_acc <= r_s2;
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + 4'd1;
      end
    end
  end

  assign o_acc = r_acc;
endmodule

module quad_step_decoder #(
  parameter int FILT_LEN = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       a_in,
  input  logic       b_in,
  input  logic       err_clr,
  output logic       step,
  output logic       up_down,
  output logic       err,
  output logic [1:0] phase
);
  logic [1:0] w_pin, w_cur, w_up_nxt, w_dn_nxt;
  logic       w_up, w_dn, w_bad;
  logic [1:0] r_prev;
  logic       r_step, r_up_down, r_err;

  assign w_pin = {a_in, b_in};

  for (genvar g = 0; g < 2; g++) begin : g_chan
    quad_step_chan #(.FILT_LEN(FILT_LEN)) u_chan (
      .clk  (clk),
      .rst  (rst),
      .i_in (w_pin[g]),
      .o_acc(w_cur[g])
    );
  end

  // Gray successor of prev in the up (A leads B) and down directions.
  assign w_up_nxt = {~r_prev[0], r_prev[1]};
  assign w_dn_nxt = {r_prev[0], ~r_prev[1]};
  assign w_up     = (w_cur == w_up_nxt);
  assign w_dn     = (w_cur == w_dn_nxt);
  assign w_bad    = ((w_cur ^ r_prev) == 2'b11);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_prev    <= 2'b00;
      r_step    <= 1'b0;
      r_up_down <= 1'b1;
      r_err     <= 1'b0;
    end else begin
      r_prev <= w_cur;
      r_step <= w_up | w_dn;
      if (w_up)      r_up_down <= 1'b1;
      else if (w_dn) r_up_down <= 1'b0;
      if (w_bad)        r_err <= 1'b1;
      else if (err_clr) r_err <= 1'b0;
    end
  end

  assign step    = r_step;
  assign up_down = r_up_down;
  assign err     = r_err;
  assign phase   = w_cur;
endmodule

// File: tb/tb_quad_step_decoder.sv
// Bench for quad_step_decoder: window-based behavioural model compared every
// cycle, directed scenarios with literal expectations, then random phase traffic.

module tb_quad_step_decoder;
  localparam int F = 4;

  logic       clk = 1'b0;
  logic       rst, a_in, b_in, err_clr;
  logic       step, up_down, err;
  logic [1:0] phase;

  int ncmp = 0, nerr = 0, nstep = 0;
  bit chk_on = 0;

  quad_step_decoder #(.FILT_LEN(F)) dut (
    .clk(clk), .rst(rst), .a_in(a_in), .b_in(b_in), .err_clr(err_clr),
    .step(step), .up_down(up_down), .err(err), .phase(phase)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  // qa/qb hold the pin samples since reset, prefixed by the two zero values the
  // synchronizer holds out of reset; the filtered value seen in a cycle lags the
  // pin by two samples. A channel flips once its last F filtered samples all
  // disagree with the accepted value.
  logic       ma, mb, mstep, mud, merr;
  logic [1:0] mprev;
  logic       qa[$], qb[$];

  function automatic bit settled(input logic q[$], input logic acc);
    int n = q.size();
    if (n < F + 1) return 0;
    for (int j = 0; j < F; j++)
      if (q[n-2-j] == acc) return 0;
    return 1;
  endfunction

  function automatic int pos(input logic [1:0] p);
    case (p)
      2'b00: return 0;
      2'b10: return 1;
      2'b11: return 2;
      default: return 3;
    endcase
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      qa = '{1'b0, 1'b0};
      qb = '{1'b0, 1'b0};
      ma = 0; mb = 0; mprev = 2'b00; mstep = 0; mud = 1; merr = 0;
    end else begin
      logic na, nb;
      int   d;
      na = settled(qa, ma) ? ~ma : ma;
      nb = settled(qb, mb) ? ~mb : mb;
      qa.push_back(a_in);
      qb.push_back(b_in);
      if (qa.size() > 40) begin void'(qa.pop_front()); void'(qb.pop_front()); end
      d = (pos({ma, mb}) - pos(mprev)) & 3;
      mstep = (d == 1) || (d == 3);
      if (d == 1) mud = 1;
      if (d == 3) mud = 0;
      if (d == 2) merr = 1;
      else if (err_clr) merr = 0;
      mprev = {ma, mb};
      ma = na;
      mb = nb;
    end
  end

  always @(negedge clk) begin
    if (step === 1'b1) nstep++;
    if (chk_on) begin
      ncmp += 4;
      if (step !== mstep)      begin nerr++; $display("FAIL step t=%0t: got %b expected %b", $time, step, mstep); end
      if (up_down !== mud)     begin nerr++; $display("FAIL up_down t=%0t: got %b expected %b", $time, up_down, mud); end
      if (err !== merr)        begin nerr++; $display("FAIL err t=%0t: got %b expected %b", $time, err, merr); end
      if (phase !== {ma, mb})  begin nerr++; $display("FAIL phase t=%0t: got %b expected %b", $time, phase, {ma, mb}); end
    end
  end

  // ---------------- helpers ----------------
  task automatic chk(input string nm, input int act, input int exp);
    ncmp++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic hold(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clr_pulse();
    err_clr = 1; hold(1); err_clr = 0;
  endtask

  task automatic wait_step(output int lat);
    lat = 0;
    do begin
      @(posedge clk); @(negedge clk); lat++;
    end while (step !== 1'b1 && lat < 30);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int s0, lat, n;
    rst = 1; a_in = 1; b_in = 1; err_clr = 0;
    hold(1);
    chk_on = 1;
    hold(4);
    chk("rst_step", int'(step), 0);
    chk("rst_up_down", int'(up_down), 1);
    chk("rst_err", int'(err), 0);
    chk("rst_phase", int'(phase), 0);

    // Both channels accepted together out of reset: illegal 00->11.
    s0 = nstep;
    rst = 0;
    hold(15);
    chk("rst_illegal_err", int'(err), 1);
    chk("rst_illegal_nostep", nstep - s0, 0);
    a_in = 0; b_in = 0; hold(15);
    clr_pulse(); hold(1);
    chk("clr_err", int'(err), 0);

    // Up rotation with first-pulse latency.
    s0 = nstep;
    a_in = 1;
    wait_step(lat);
    chk("up_latency", lat, 7);
    hold(19);
    b_in = 1; hold(20);
    a_in = 0; hold(20);
    b_in = 0; hold(20);
    chk("up_steps", nstep - s0, 4);
    chk("up_dir", int'(up_down), 1);

    // Down rotation, then one up move.
    s0 = nstep;
    b_in = 1; hold(20);
    chk("down_first_dir", int'(up_down), 0);
    a_in = 1; hold(20);
    b_in = 0; hold(20);
    a_in = 0; hold(20);
    chk("down_steps", nstep - s0, 4);
    chk("down_dir", int'(up_down), 0);
    s0 = nstep;
    a_in = 1; hold(20);
    chk("reverse_dir", int'(up_down), 1);
    chk("reverse_step", nstep - s0, 1);
    a_in = 0; hold(20);

    // Glitch rejection at the filter boundary.
    s0 = nstep;
    a_in = 1; hold(3); a_in = 0; hold(20);
    chk("glitch3_steps", nstep - s0, 0);
    chk("glitch3_phase", int'(phase), 0);
    a_in = 1; hold(4); a_in = 0; hold(20);
    chk("glitch4_steps", nstep - s0, 2);

    // Illegal moves and err_clr priority.
    s0 = nstep;
    a_in = 1; b_in = 1; hold(20);
    chk("illegal_err", int'(err), 1);
    chk("illegal_nostep", nstep - s0, 0);
    clr_pulse(); hold(1);
    chk("illegal_clr", int'(err), 0);
    a_in = 0; b_in = 0;
    n = 0;
    do begin hold(1); n++; end while (phase !== 2'b00 && n < 30);
    chk("illegal2_accept_timeout", int'(phase === 2'b00), 1);
    err_clr = 1; hold(1); err_clr = 0;
    chk("set_wins_over_clr", int'(err), 1);
    hold(2);
    clr_pulse(); hold(1);
    chk("lone_clr", int'(err), 0);
    a_in = 1; b_in = 1; hold(20);
    b_in = 0; hold(20);
    a_in = 0; hold(20);
    chk("pre_rst_dir", int'(up_down), 0);
    chk("pre_rst_err", int'(err), 1);

    // Async reset while the A filter is mid-count.
    a_in = 1;
    repeat (4) @(posedge clk);
    #2 rst = 1;
    #1;
    chk("midrst_step", int'(step), 0);
    chk("midrst_dir", int'(up_down), 1);
    chk("midrst_err", int'(err), 0);
    chk("midrst_phase", int'(phase), 0);
    @(negedge clk);
    rst = 0;
    wait_step(lat);
    chk("midrst_latency", lat, 7);
    chk("midrst_dir_after", int'(up_down), 1);
    hold(20);

    // Random phase traffic, including simultaneous changes and short pulses.
    for (int i = 0; i < 800; i++) begin
      a_in = 1'($urandom_range(0, 1));
      b_in = 1'($urandom_range(0, 1));
      err_clr = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 149) == 0) begin
        #1 rst = 1; hold(1); rst = 0;
      end
      hold($urandom_range(1, 10));
    end
    err_clr = 0;
    hold(20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule
